// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//   AHB-Lite slave backed by a word-organised internal memory. It takes the
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA stream from an upstream bridge and
//   supports zero or more programmable wait states, byte/halfword/word
//   writes, and a two-cycle ERROR response for illegal accesses.
//
// Parameters
//   ADDR_WIDTH  : width of haddr (byte address)
//   DEPTH       : number of 32-bit words; legal byte addresses 0..DEPTH*4-1
//   WAIT_STATES : stall cycles inserted on every OKAY transfer (0..7)
//
// Ports
//   hclk       in   clock, rising edge
//   hresetn    in   synchronous active-low reset
//   hsel       in   slave select
//   haddr      in   byte address (address phase)
//   htrans     in   IDLE/BUSY/NONSEQ/SEQ
//   hwrite     in   1 = write
//   hsize      in   000 byte, 001 halfword, 010 word
//   hburst     in   accepted and ignored
//   hwdata     in   write data (data phase)
//   hready     in   bus HREADY
//   hreadyout  out  slave ready
//   hresp      out  0 OKAY, 1 ERROR
//   hrdata     out  read data, valid in the final cycle of a read data phase
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [31:0]           hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [31:0]           hrdata
);

  localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);
  localparam logic [2:0]  WS    = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  // Little-endian byte-lane enables for a transfer of the given size.
  function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                           input logic [1:0] a);
    logic [3:0] m;
    case (size)
      3'b000:  m = 4'b0001 << a;
      3'b001:  m = a[1] ? 4'b1100 : 4'b0011;
      3'b010:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replace the enabled byte lanes of 'base' with those of 'upd'.
  function automatic logic [31:0] merge_lanes(input logic [31:0] base,
                                              input logic [31:0] upd,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    r = base;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r[8*b +: 8] = upd[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  function automatic logic access_legal(input logic [2:0]            size,
                                        input logic [ADDR_WIDTH-1:0] a);
    logic ok;
    case (size)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~a[0];
      3'b010:  ok = (a[1:0] == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok && (32'(a) < LIMIT);
  endfunction

  logic [31:0]           mem [DEPTH];

  state_t                state;
  logic [2:0]            wcnt;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic                  wr_p1;
  logic [3:0]            mask_p1;

  logic                  accept;
  logic                  take;
  logic                  legal;
  logic                  commit;
  logic                  rd_load;
  logic [IDX_W-1:0]      rd_idx;
  logic [31:0]           rd_word;
  logic                  unused_ok;

  assign unused_ok = &{1'b0, hburst, htrans[0]};

  // ---- address phase: decode of the incoming request ----
  assign accept = hsel & hready & htrans[1];
  // A new request is only taken in states whose cycle ends a transfer.
  assign take   = accept & ((state == S_IDLE) | (state == S_DATA) | (state == S_ERR2));
  assign legal  = access_legal(hsize, haddr);
  assign commit = (state == S_DATA) & wr_p1;

  // hrdata is loaded on the edge that enters DATA for a read. With no wait
  // states that is the accept edge itself, so the live bus address is used.
  always_comb begin
    rd_load = 1'b0;
    rd_idx  = word_idx(addr_p1);
    if (take && legal && (WS == 3'd0) && !hwrite) begin
      rd_load = 1'b1;
      rd_idx  = word_idx(haddr);
    end else if ((state == S_WAIT) && (wcnt == 3'd1) && !wr_p1) begin
      rd_load = 1'b1;
    end
  end

  // A write committing on the same edge to the same word is forwarded so a
  // back-to-back read sees the new data without a stall.
  always_comb begin
    rd_word = mem[rd_idx];
    if (commit && (word_idx(addr_p1) == rd_idx))
      rd_word = merge_lanes(mem[rd_idx], hwdata, mask_p1);
  end

  // ---- data phase: memory write at the edge ending DATA ----
  always_ff @(posedge hclk) begin
    if (hresetn && commit)
      mem[word_idx(addr_p1)] <= merge_lanes(mem[word_idx(addr_p1)], hwdata, mask_p1);
  end

  // ---- data phase: control FSM, registered outputs, read data ----
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state     <= S_IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= 32'h0;
      wcnt      <= 3'd0;
      addr_p1   <= '0;
      wr_p1     <= 1'b0;
      mask_p1   <= 4'h0;
    end else begin
      if (rd_load) hrdata <= rd_word;

      case (state)
        S_IDLE, S_DATA, S_ERR2: begin
          if (take) begin
            addr_p1 <= haddr;
            wr_p1   <= hwrite & legal;
            mask_p1 <= lane_mask(hsize, haddr[1:0]);
            if (!legal) begin
              state     <= S_ERR1;
              hreadyout <= 1'b0;
              hresp     <= 1'b1;
            end else if (WS != 3'd0) begin
              state     <= S_WAIT;
              wcnt      <= WS;
              hreadyout <= 1'b0;
              hresp     <= 1'b0;
            end else begin
              state     <= S_DATA;
              hreadyout <= 1'b1;
              hresp     <= 1'b0;
            end
          end else begin
            state     <= S_IDLE;
            wr_p1     <= 1'b0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
          end
        end
        S_WAIT: begin
          if (wcnt == 3'd1) begin
            state     <= S_DATA;
            hreadyout <= 1'b1;
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
        end
      endcase
    end
  end

endmodule
